// File: rtl/full_adder_using_half_adder.sv
// WIDTH-bit ripple-carry adder where each bit is two half adders plus an OR.
// Latency: 0 cycles when OUT_REG=0, 1 cycle when OUT_REG=1.
// Backpressure: none; a new result is accepted and produced every cycle.

// Half adder leaf cell: s = x ^ y, c = x & y.
// Latency: combinational.
// Backpressure: none.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_using_half_adder #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);
    logic [WIDTH-1:0] sum_c;
    logic             c_out_c;

    // Each bit owns its carry signal so the ripple chain is a series of
    // distinct nets rather than one vector feeding back into itself.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        logic carry_in;
        logic carry_out;
        logic s0;
        logic c0;
        logic c1;

        if (i == 0) begin : gen_first
            assign carry_in = c_in;
        end else begin : gen_chain
            assign carry_in = gen_bit[i-1].carry_out;
        end

        half_adder ha0 (.x(a[i]), .y(b[i]),     .s(s0),       .c(c0));
        half_adder ha1 (.x(s0),   .y(carry_in), .s(sum_c[i]), .c(c1));

        assign carry_out = c0 | c1;
    end

    assign c_out_c = gen_bit[WIDTH-1].carry_out;

    if (OUT_REG) begin : gen_reg
        logic [WIDTH-1:0] sum_q;
        logic             c_out_q;
        logic             valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                c_out_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_c;
                c_out_q <= c_out_c;
                valid_q <= 1'b1;
            end
        end

        assign sum       = sum_q;
        assign c_out     = c_out_q;
        assign out_valid = valid_q;
    end else begin : gen_comb
        // clk and rst have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign sum       = sum_c;
        assign c_out     = c_out_c;
        assign out_valid = 1'b1;
    end
endmodule

// File: tb/tb_full_adder_using_half_adder.sv
// Randomized and directed checks of the half-adder-built adder against a+b+c_in.
module tb_full_adder_using_half_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // 1-bit combinational
    logic a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic s1, co1, v1;
    // 4-bit combinational
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic ci4 = 1'b0, co4, v4;
    // 8-bit combinational
    logic [7:0] a8c = '0, b8c = '0, s8c;
    logic ci8c = 1'b0, co8c, v8c;
    // 8-bit registered
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic ci8 = 1'b0, co8, v8;

    full_adder_using_half_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1),
        .sum(s1), .c_out(co1), .out_valid(v1));
    full_adder_using_half_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(ci4),
        .sum(s4), .c_out(co4), .out_valid(v4));
    full_adder_using_half_adder #(.WIDTH(8), .OUT_REG(1'b0)) u_w8c (
        .clk(clk), .rst(rst), .a(a8c), .b(b8c), .c_in(ci8c),
        .sum(s8c), .c_out(co8c), .out_valid(v8c));
    full_adder_using_half_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8r (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8),
        .sum(s8), .c_out(co8), .out_valid(v8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned sum of 8-bit operands plus carry, 9 bits wide.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [8:0] prev_exp;
    logic [4:0] exp4;

    initial begin
        // 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, ci1} = v;
            #100;
            check($sformatf("w1_tt_%0d", i), 32'({co1, s1}), 32'(tt_exp[i]));
        end
        check("w1_valid", 32'(v1), 32'd1);

        // c_in toggle only
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; #1;
        check("w1_cin0", 32'({s1, co1}), 32'b10);
        ci1 = 1'b1; #1;
        check("w1_cin1", 32'({s1, co1}), 32'b01);

        // 4-bit directed
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; #1;
        check("w4_full_ripple", 32'({co4, s4}), 32'h10);
        a4 = 4'h9; b4 = 4'h6; ci4 = 1'b0; #1;
        check("w4_9p6", 32'({co4, s4}), 32'h0F);
        check("w4_valid", 32'(v4), 32'd1);

        // Random combinational
        for (int i = 0; i < 20; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            a8c = 8'($urandom); b8c = 8'($urandom); ci8c = 1'($urandom);
            #1;
            exp4 = 5'(a4) + 5'(b4) + 5'(ci4);
            check("w4_rand", 32'({co4, s4}), 32'(exp4));
            check("w8c_rand", 32'({co8c, s8c}), 32'(ref_add8(a8c, b8c, ci8c)));
        end

        // Registered: reset held two edges
        @(negedge clk);
        rst = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
        tick();
        check("w8r_rst_e1", 32'({v8, co8, s8}), 32'h0);
        tick();
        check("w8r_rst_e2", 32'({v8, co8, s8}), 32'h0);
        rst = 1'b0;
        tick();
        check("w8r_first", 32'({v8, co8, s8}), 32'h300);

        // Back-to-back directed vectors, one-cycle latency
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b1;
        #1;
        check("w8r_hold_before_edge", 32'({v8, co8, s8}), 32'h300);
        tick();
        check("w8r_v1", 32'({v8, co8, s8}), 32'h231);
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
        #1;
        check("w8r_hold_v1", 32'({v8, co8, s8}), 32'h231);
        tick();
        check("w8r_v2", 32'({v8, co8, s8}), 32'h300);

        // Random stream
        prev_exp = 9'h100;
        for (int i = 0; i < 30; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            #1;
            check("w8r_stream_hold", 32'({co8, s8}), 32'(prev_exp));
            prev_exp = ref_add8(a8, b8, ci8);
            tick();
            check("w8r_stream", 32'({v8, co8, s8}), 32'({1'b1, prev_exp}));
        end

        // Mid-stream reset discards the in-flight vector
        rst = 1'b1; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b1;
        tick();
        check("w8r_mid_rst", 32'({v8, co8, s8}), 32'h0);
        rst = 1'b0; a8 = 8'hC0; b8 = 8'h50; ci8 = 1'b1;
        #1;
        check("w8r_rst_hold", 32'({v8, co8, s8}), 32'h0);
        tick();
        check("w8r_resume", 32'({v8, co8, s8}), 32'({1'b1, ref_add8(8'hC0, 8'h50, 1'b1)}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
